// File: rtl/clock_ui_pkg.sv
// Shared types and default timing constants for the clock front-panel / alarm-ring controller.
package clock_ui_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_TIME  = 2'd1,
        SET_ALARM = 2'd2
    } ui_state_t;

    typedef enum logic [1:0] {
        R_QUIET  = 2'd0,
        R_RING   = 2'd1,
        R_SNOOZE = 2'd2,
        R_DONE   = 2'd3
    } ring_state_t;

    typedef enum logic {
        F_MIN = 1'b0,
        F_HRS = 1'b1
    } field_t;

    localparam int RPT_DLY_DEF  = 2;
    localparam int IDLE_TO_DEF  = 10;
    localparam int RING_MAX_DEF = 30;
    localparam int SNOOZE_DEF   = 5;

    function automatic int cnt_w(input int p);
        return (p < 2) ? 1 : $clog2(p);
    endfunction

endpackage

// File: rtl/clock_ui_ctrl_btn_press.sv
// Button edge detector: registers the raw level, flags the press cycle and counts how long it stays held.
module btn_press #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn,
    output logic         press,
    output logic [W-1:0] held_cnt
);

    logic btn_q;

    // held_cnt is 0 on the press cycle and the cycle after, then climbs once per further held cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q    <= 1'b0;
            held_cnt <= '0;
        end else begin
            btn_q <= btn;
            if (btn && btn_q) begin
                if (held_cnt != '1)
                    held_cnt <= held_cnt + W'(1);
            end else begin
                held_cnt <= '0;
            end
        end
    end

    assign press = btn & ~btn_q;

endmodule

// File: rtl/clock_ui_ctrl.sv
// Front-panel UI sequencer and alarm buzzer sequencer for the 1 Hz clock/alarm datapath.
// ui:   RUN | counters free-run     SET_TIME | adv edits time     SET_ALARM | adv edits alarm
// ring: R_QUIET | armed, silent  R_RING | buzzing  R_SNOOZE | paused  R_DONE | silenced until match drops
module clock_ui_ctrl
    import clock_ui_pkg::*;
#(
    parameter int RPT_DLY  = RPT_DLY_DEF,
    parameter int IDLE_TO  = IDLE_TO_DEF,
    parameter int RING_MAX = RING_MAX_DEF,
    parameter int SNOOZE   = SNOOZE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       field_btn,
    input  logic       adv_btn,
    input  logic       stop_btn,
    input  logic       snooze_btn,
    input  logic       alarm_on,
    input  logic       alarm_match,
    output logic       timeset,
    output logic       alarmset,
    output logic       minadv,
    output logic       hrsadv,
    output logic       buzz,
    output logic [1:0] ui_state
);

    localparam int HW = cnt_w(RPT_DLY);
    localparam int IW = cnt_w(IDLE_TO);
    localparam int RW = cnt_w(RING_MAX);
    localparam int SW = cnt_w(SNOOZE);

    localparam logic [HW-1:0] RPT_TH     = HW'(RPT_DLY - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TO - 1);
    localparam logic [RW-1:0] RING_LAST  = RW'(RING_MAX - 1);
    localparam logic [SW-1:0] SNZ_LAST   = SW'(SNOOZE - 1);

    logic          mode_press, field_press, adv_press, stop_press, snooze_press;
    logic [HW-1:0] adv_held;
    logic          mode_held_unused, field_held_unused, stop_held_unused, snooze_held_unused;

    btn_press #(.W(1))  u_mode   (.clk(clk), .rst(rst), .btn(mode_btn),   .press(mode_press),   .held_cnt(mode_held_unused));
    btn_press #(.W(1))  u_field  (.clk(clk), .rst(rst), .btn(field_btn),  .press(field_press),  .held_cnt(field_held_unused));
    btn_press #(.W(HW)) u_adv    (.clk(clk), .rst(rst), .btn(adv_btn),    .press(adv_press),    .held_cnt(adv_held));
    btn_press #(.W(1))  u_stop   (.clk(clk), .rst(rst), .btn(stop_btn),   .press(stop_press),   .held_cnt(stop_held_unused));
    btn_press #(.W(1))  u_snooze (.clk(clk), .rst(rst), .btn(snooze_btn), .press(snooze_press), .held_cnt(snooze_held_unused));

    ui_state_t   ui_q, ui_d;
    field_t      field_q, field_d;
    logic [IW-1:0] idle_q, idle_d;
    ring_state_t ring_q, ring_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic        match_q;
    logic        set_mode, step, match_rise;

    assign set_mode   = (ui_q != RUN);
    assign match_rise = alarm_match & ~match_q;
    // A mode press swallows any simultaneous advance.
    assign step = set_mode & ~mode_press &
                  (adv_press | (adv_btn & ~adv_press & (adv_held >= RPT_TH)));

    always_comb begin
        ui_d    = ui_q;
        field_d = field_q;
        idle_d  = idle_q;
        if (mode_press) begin
            case (ui_q)
                RUN:      ui_d = SET_TIME;
                SET_TIME: ui_d = SET_ALARM;
                default:  ui_d = RUN;
            endcase
            field_d = F_MIN;
            idle_d  = '0;
        end else if (!set_mode) begin
            idle_d = '0;
        end else if (field_press || adv_btn) begin
            idle_d = '0;
            if (field_press)
                field_d = (field_q == F_MIN) ? F_HRS : F_MIN;
        end else if (idle_q == IDLE_LAST) begin
            ui_d    = RUN;
            field_d = F_MIN;
            idle_d  = '0;
        end else begin
            idle_d = idle_q + IW'(1);
        end
    end

    always_comb begin
        ring_d = ring_q;
        rcnt_d = rcnt_q;
        scnt_d = scnt_q;
        if (!alarm_on) begin
            ring_d = R_QUIET;
        end else begin
            case (ring_q)
                R_QUIET: begin
                    if (match_rise && ui_q != SET_ALARM) begin
                        ring_d = R_RING;
                        rcnt_d = '0;
                    end
                end
                R_RING: begin
                    if (stop_press) begin
                        ring_d = R_DONE;
                    end else if (snooze_press) begin
                        ring_d = R_SNOOZE;
                        scnt_d = '0;
                    end else if (rcnt_q == RING_LAST) begin
                        ring_d = R_DONE;
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end
                R_SNOOZE: begin
                    if (stop_press) begin
                        ring_d = R_DONE;
                    end else if (scnt_q == SNZ_LAST) begin
                        ring_d = R_RING;
                        rcnt_d = '0;
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end
                R_DONE: begin
                    if (!alarm_match)
                        ring_d = R_QUIET;
                end
                default: ring_d = R_QUIET;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ui_q     <= RUN;
            field_q  <= F_MIN;
            idle_q   <= '0;
            ring_q   <= R_QUIET;
            rcnt_q   <= '0;
            scnt_q   <= '0;
            match_q  <= 1'b0;
            timeset  <= 1'b0;
            alarmset <= 1'b0;
            minadv   <= 1'b0;
            hrsadv   <= 1'b0;
            buzz     <= 1'b0;
        end else begin
            ui_q     <= ui_d;
            field_q  <= field_d;
            idle_q   <= idle_d;
            ring_q   <= ring_d;
            rcnt_q   <= rcnt_d;
            scnt_q   <= scnt_d;
            match_q  <= alarm_match;
            timeset  <= (ui_d == SET_TIME);
            alarmset <= (ui_d == SET_ALARM);
            minadv   <= step & (field_q == F_MIN);
            hrsadv   <= step & (field_q == F_HRS);
            buzz     <= (ring_d == R_RING);
        end
    end

    assign ui_state = ui_q;

endmodule

// File: tb/tb_clock_ui_ctrl.sv
// Self-checking bench for clock_ui_ctrl: behavioural model compared every cycle, directed scenarios, random soak.
module tb_clock_ui_ctrl;

    localparam int RPT_DLY  = 2;
    localparam int IDLE_TO  = 10;
    localparam int RING_MAX = 30;
    localparam int SNOOZE   = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mode_btn = 0, field_btn = 0, adv_btn = 0, stop_btn = 0, snooze_btn = 0;
    logic alarm_on = 0, alarm_match = 0;
    logic timeset, alarmset, minadv, hrsadv, buzz;
    logic [1:0] ui_state;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    clock_ui_ctrl dut (
        .clk(clk), .rst(rst),
        .mode_btn(mode_btn), .field_btn(field_btn), .adv_btn(adv_btn),
        .stop_btn(stop_btn), .snooze_btn(snooze_btn),
        .alarm_on(alarm_on), .alarm_match(alarm_match),
        .timeset(timeset), .alarmset(alarmset), .minadv(minadv), .hrsadv(hrsadv),
        .buzz(buzz), .ui_state(ui_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Model: mode 0=RUN 1=SET_TIME 2=SET_ALARM; ring 0=quiet 1=ringing 2=snoozing 3=silenced.
    int m_ui, m_idle, m_ring, m_rt, m_st, hold_len;
    bit m_field;
    bit p_mode, p_field, p_adv, p_stop, p_snz, p_match;
    bit e_ts, e_as, e_min, e_hrs, e_buzz;
    int e_ui;

    always @(posedge clk) begin
        bit mp, fp, ap, sp, np, strobe;
        if (rst) begin
            m_ui = 0; m_field = 0; m_idle = 0; m_ring = 0; m_rt = 0; m_st = 0; hold_len = 0;
            p_mode = 0; p_field = 0; p_adv = 0; p_stop = 0; p_snz = 0; p_match = 0;
            e_ts = 0; e_as = 0; e_min = 0; e_hrs = 0; e_buzz = 0; e_ui = 0;
        end else begin
            mp = mode_btn && !p_mode;
            fp = field_btn && !p_field;
            ap = adv_btn && !p_adv;
            sp = stop_btn && !p_stop;
            np = snooze_btn && !p_snz;
            hold_len = adv_btn ? hold_len + 1 : 0;
            // repeat once the button has stayed down RPT_DLY cycles past its press cycle
            strobe = (m_ui != 0) && !mp && adv_btn && (ap || (hold_len - 1 >= RPT_DLY));
            e_min = strobe && !m_field;
            e_hrs = strobe && m_field;

            if (!alarm_on) m_ring = 0;
            else case (m_ring)
                0: if (alarm_match && !p_match && m_ui != 2) begin m_ring = 1; m_rt = 0; end
                1: if (sp) m_ring = 3;
                   else if (np) begin m_ring = 2; m_st = 0; end
                   else begin m_rt++; if (m_rt >= RING_MAX) m_ring = 3; end
                2: if (sp) m_ring = 3;
                   else begin m_st++; if (m_st >= SNOOZE) begin m_ring = 1; m_rt = 0; end end
                default: if (!alarm_match) m_ring = 0;
            endcase

            if (mp) begin
                m_ui = (m_ui + 1) % 3; m_field = 0; m_idle = 0;
            end else if (m_ui != 0) begin
                if (fp || adv_btn) begin
                    m_idle = 0;
                    if (fp) m_field = !m_field;
                end else begin
                    m_idle++;
                    if (m_idle >= IDLE_TO) begin m_ui = 0; m_field = 0; m_idle = 0; end
                end
            end

            e_ts = (m_ui == 1); e_as = (m_ui == 2); e_buzz = (m_ring == 1); e_ui = m_ui;
            p_mode = mode_btn; p_field = field_btn; p_adv = adv_btn;
            p_stop = stop_btn; p_snz = snooze_btn; p_match = alarm_match;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ui_state", ui_state, 2'(e_ui));
            chk("timeset",  {1'b0, timeset},  {1'b0, e_ts});
            chk("alarmset", {1'b0, alarmset}, {1'b0, e_as});
            chk("minadv",   {1'b0, minadv},   {1'b0, e_min});
            chk("hrsadv",   {1'b0, hrsadv},   {1'b0, e_hrs});
            chk("buzz",     {1'b0, buzz},     {1'b0, e_buzz});
            chk("set_excl", {1'b0, timeset & alarmset}, 2'd0);
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        tick(2);
        chk_en = 1;
        rst = 0;
        tick(1);
        chk("lit_reset_ui", ui_state, 2'd0);
        chk("lit_reset_out", {timeset | alarmset | minadv, hrsadv | buzz}, 2'd0);

        // mode steps RUN -> SET_TIME -> SET_ALARM -> RUN
        mode_btn = 1; tick(1); chk("lit_mode1", ui_state, 2'd1); chk("lit_ts1", {1'b0, timeset}, 2'd1);
        mode_btn = 0; tick(1);
        mode_btn = 1; tick(1); chk("lit_mode2", ui_state, 2'd2); chk("lit_as2", {timeset, alarmset}, 2'b01);
        mode_btn = 0; tick(1);
        mode_btn = 1; tick(1); chk("lit_mode0", ui_state, 2'd0);
        mode_btn = 0; tick(1);

        // auto-repeat on held adv in SET_TIME
        mode_btn = 1; tick(1); mode_btn = 0; tick(1);
        adv_btn = 1;
        tick(1); chk("lit_rpt1", {hrsadv, minadv}, 2'b01);
        tick(1); chk("lit_rpt2", {hrsadv, minadv}, 2'b00);
        tick(1); chk("lit_rpt3", {hrsadv, minadv}, 2'b01);
        tick(1); chk("lit_rpt4", {hrsadv, minadv}, 2'b01);
        tick(1); chk("lit_rpt5", {hrsadv, minadv}, 2'b01);
        adv_btn = 0;
        tick(1); chk("lit_rpt6", {hrsadv, minadv}, 2'b00);

        // SET_ALARM, field to HRS, adv tap, then idle timeout
        mode_btn = 1; tick(1); mode_btn = 0; tick(1);
        field_btn = 1; tick(1); field_btn = 0; tick(1);
        adv_btn = 1; tick(1); chk("lit_hrs_tap", {hrsadv, minadv}, 2'b10);
        adv_btn = 0; tick(1); chk("lit_hrs_off", {hrsadv, minadv}, 2'b00);
        tick(8); chk("lit_idle9", ui_state, 2'd2);
        tick(1); chk("lit_idle10", ui_state, 2'd0);

        // ring, snooze, ring again, stop, no re-ring
        alarm_on = 1; alarm_match = 1;
        tick(1); chk("lit_ring_on", {1'b0, buzz}, 2'd1);
        snooze_btn = 1; tick(1); snooze_btn = 0; chk("lit_snz0", {1'b0, buzz}, 2'd0);
        tick(4); chk("lit_snz4", {1'b0, buzz}, 2'd0);
        tick(1); chk("lit_snz_end", {1'b0, buzz}, 2'd1);
        stop_btn = 1; tick(1); stop_btn = 0; chk("lit_stop", {1'b0, buzz}, 2'd0);
        tick(3); chk("lit_no_rering", {1'b0, buzz}, 2'd0);
        alarm_match = 0; tick(1);

        // unattended ring lasts exactly RING_MAX cycles
        alarm_match = 1; tick(1); chk("lit_rmax_1", {1'b0, buzz}, 2'd1);
        tick(RING_MAX - 1); chk("lit_rmax_30", {1'b0, buzz}, 2'd1);
        tick(1); chk("lit_rmax_31", {1'b0, buzz}, 2'd0);
        alarm_match = 0; tick(1);

        // stop and snooze together: stop wins
        alarm_match = 1; tick(1);
        stop_btn = 1; snooze_btn = 1; tick(1); stop_btn = 0; snooze_btn = 0;
        tick(6); chk("lit_stop_wins", {1'b0, buzz}, 2'd0);
        alarm_match = 0; tick(1);
        alarm_match = 1; tick(1); chk("lit_ring_again", {1'b0, buzz}, 2'd1);
        alarm_on = 0; tick(1); chk("lit_disarm", {1'b0, buzz}, 2'd0);
        alarm_on = 1; alarm_match = 0; tick(1);

        // reset while ringing in SET_TIME with adv auto-repeating
        mode_btn = 1; tick(1); mode_btn = 0; alarm_match = 1; adv_btn = 1; tick(4);
        chk("lit_pre_rst", {buzz, minadv}, 2'b11);
        rst = 1; tick(1);
        chk("lit_rst_ui", ui_state, 2'd0);
        chk("lit_rst_out", {buzz | minadv, timeset}, 2'b00);
        rst = 0; adv_btn = 0; alarm_match = 0; tick(1);

        // mode + field together: only a mode step
        mode_btn = 1; field_btn = 1; tick(1); chk("lit_mf_ui", ui_state, 2'd1);
        mode_btn = 0; field_btn = 0; tick(1);
        adv_btn = 1; tick(1); chk("lit_mf_min", {hrsadv, minadv}, 2'b01);
        adv_btn = 0; tick(1);
        mode_btn = 1; adv_btn = 1; tick(1); chk("lit_ma_nostrobe", {hrsadv, minadv}, 2'b00);
        mode_btn = 0; adv_btn = 0; tick(1);

        // random soak
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0)  mode_btn   = ~mode_btn;
            if ($urandom_range(0, 5) == 0)  field_btn  = ~field_btn;
            if ($urandom_range(0, 3) == 0)  adv_btn    = ~adv_btn;
            if ($urandom_range(0, 11) == 0) stop_btn   = ~stop_btn;
            if ($urandom_range(0, 9) == 0)  snooze_btn = ~snooze_btn;
            if ($urandom_range(0, 19) == 0) alarm_match = ~alarm_match;
            if (alarm_on) begin
                if ($urandom_range(0, 79) == 0) alarm_on = 0;
            end else if ($urandom_range(0, 3) == 0) alarm_on = 1;
            rst = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        rst = 0;
        tick(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
